micro_sequencer: RTL and testbench
==================================

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 SHALL have parameter ADR_W, default 6, micro-address width (>=4).
REQ-002 SHALL have parameter STACK_DEPTH, default 4, return-stack entries (>=1).
REQ-003 SHALL have port clk  input  1  clock, rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  hold current state for this cycle.
REQ-006 SHALL have port seq_op  input  3  sequencing op from microword (encoding in package).
REQ-007 SHALL have port next_adr  input  ADR_W  microword target address.
REQ-008 SHALL have port cond_sel  input  3  [2]=invert, [1:0] select Z/N/C/V.
REQ-009 SHALL have port flags  input  4  {N,Z,C,V}.
REQ-010 SHALL have port Op  input  2  instruction op field.
REQ-011 SHALL have port Funct  input  6  instruction funct field.
REQ-012 SHALL have port adr  output  ADR_W  registered current micro-address.
REQ-013 SHALL have port stack_ovf  output  1  sticky overflow error.
REQ-014 SHALL have port stack_unf  output  1  sticky underflow error.

Function
REQ-015 SHALL update adr, stack and error flags only on rising clk; adr is a register, no combinational path to it.
REQ-016 SHALL hold adr, stack contents, stack pointer and error flags unchanged when stall=1, regardless of seq_op.
REQ-017 SHALL perform SEQ_NEXT as adr <= adr+1, modulo 2^ADR_W (wrap from all-ones to 0).
REQ-018 SHALL perform SEQ_JUMP as adr <= next_adr.
REQ-019 SHALL perform SEQ_DISP1 as adr <= DISP1[{Op,Funct[5]}] (8-entry table).
REQ-020 SHALL perform SEQ_DISP2 as adr <= DISP2[{Op,Funct[0]}] (8-entry table).
REQ-021 SHALL use default DISP1: Op=00,F5=0 ->6; Op=00,F5=1 ->7; Op=01 ->2; Op=10 ->9; Op=11 ->0; DISP2: F0=1 ->3, F0=0 ->4 for every Op.
REQ-022 SHALL perform SEQ_COND as adr <= next_adr when (selected flag XOR cond_sel[2])=1, else adr+1.
REQ-023 SHALL perform SEQ_CALL as push (adr+1) then adr <= next_adr.
REQ-024 SHALL perform SEQ_RET as adr <= top of stack, pop.
REQ-025 SHALL, on CALL with stack full, jump to next_adr, suppress push, set stack_ovf.
REQ-026 SHALL, on RET with stack empty, set adr <= 0, leave pointer at 0, set stack_unf.
REQ-027 SHALL treat undefined seq_op codes as SEQ_NEXT.
REQ-028 SHALL keep stack_ovf/stack_unf set until reset.

Reset
REQ-029 SHALL, on reset assertion, immediately force adr=0, stack pointer=0 (empty), stack_ovf=0, stack_unf=0, independent of clk and stall.
REQ-030 SHALL discard any in-progress call nesting on reset; stack entry contents need not be cleared.

Structure
REQ-031 SHALL place seq_op enum (NEXT=0, JUMP=1, DISP1=2, DISP2=3, COND=4, CALL=5, RET=6), cond_sel encodings and default DISP1/DISP2 tables in package micro_seq_pkg.
REQ-032 SHALL implement the return stack as sub-module micro_ret_stack (push/pop/full/empty/top, parameterised ADR_W, STACK_DEPTH).

Verification
REQ-033 SHALL test reset then 3 cycles SEQ_NEXT -> adr 0,1,2,3; with adr=63, SEQ_NEXT -> adr 0.
REQ-034 SHALL test SEQ_DISP1 with Op=00,Funct=6'b100000 -> adr 7; Op=10 -> 9; SEQ_DISP2 Funct[0]=1 -> 3.
REQ-035 SHALL test SEQ_COND next_adr=20, cond_sel=3'b001 (Z), Z=1 -> adr 20; cond_sel=3'b101, Z=1 -> adr+1.
REQ-036 SHALL test CALL at adr 5 to 12, then RET -> adr 6; five nested CALLs (depth 4) -> stack_ovf=1, RET x4 returns in LIFO order.
REQ-037 SHALL test RET on empty stack -> adr 0, stack_unf=1 sticky; stall=1 during CALL -> adr and pointer unchanged.
REQ-038 SHALL test reset asserted mid-nesting between clock edges -> adr=0, flags 0 immediately, following RET underflows.

Source files
------------

// File: rtl/micro_seq_pkg.sv
// Shared encodings for the micro-sequencer: sequencing ops, condition
// selects and the default dispatch tables.
package micro_seq_pkg;

    typedef enum logic [2:0] {
        SEQ_NEXT  = 3'd0,
        SEQ_JUMP  = 3'd1,
        SEQ_DISP1 = 3'd2,
        SEQ_DISP2 = 3'd3,
        SEQ_COND  = 3'd4,
        SEQ_CALL  = 3'd5,
        SEQ_RET   = 3'd6
    } seq_op_e;

    // cond_sel[1:0] picks a flag by its position in {N,Z,C,V}; cond_sel[2] inverts
    localparam logic [1:0] COND_N = 2'd0;
    localparam logic [1:0] COND_Z = 2'd1;
    localparam logic [1:0] COND_C = 2'd2;
    localparam logic [1:0] COND_V = 2'd3;
    localparam int unsigned COND_INV_BIT = 2;

    localparam int unsigned DISP_W = 8;

    // Indexed by {Op, Funct[5]}
    localparam logic [DISP_W-1:0] DISP1_TABLE [8] = '{
        8'd6, 8'd7, 8'd2, 8'd2, 8'd9, 8'd9, 8'd0, 8'd0
    };

    // Indexed by {Op, Funct[0]}
    localparam logic [DISP_W-1:0] DISP2_TABLE [8] = '{
        8'd4, 8'd3, 8'd4, 8'd3, 8'd4, 8'd3, 8'd4, 8'd3
    };

endpackage

// File: rtl/micro_ret_stack.sv
// LIFO of return addresses; storage is not reset, only the pointer is.
module micro_ret_stack #(
    parameter int unsigned ADR_W       = 6,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [ADR_W-1:0] push_data,
    output logic [ADR_W-1:0] top_c,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned PTR_W = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PTR_W-1:0] ptr;
    logic [ADR_W-1:0] mem [STACK_DEPTH];

    assign full_c  = (ptr == PTR_W'(STACK_DEPTH));
    assign empty_c = (ptr == '0);
    assign top_c   = empty_c ? '0 : mem[IDX_W'(ptr - PTR_W'(1))];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (push && !full_c) begin
            ptr <= ptr + PTR_W'(1);
        end else if (pop && !empty_c) begin
            ptr <= ptr - PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full_c) begin
            mem[IDX_W'(ptr)] <= push_data;
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microcode address sequencer: next/jump/dispatch/conditional branch and
// call/return through a small return stack with sticky error flags.
module micro_sequencer
    import micro_seq_pkg::*;
#(
    parameter int unsigned ADR_W       = 6,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [2:0]       seq_op,
    input  logic [ADR_W-1:0] next_adr,
    input  logic [2:0]       cond_sel,
    input  logic [3:0]       flags,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    output logic [ADR_W-1:0] adr,
    output logic             stack_ovf,
    output logic             stack_unf
);

    logic [ADR_W-1:0] adr_inc;
    logic [ADR_W-1:0] adr_next;
    logic [ADR_W-1:0] stack_top_c;
    logic             stack_full_c;
    logic             stack_empty_c;
    logic             push;
    logic             pop;
    logic             set_ovf;
    logic             set_unf;
    logic             cond_flag;
    logic             unused_funct;

    assign adr_inc      = adr + ADR_W'(1);
    assign unused_funct = ^Funct[4:1];

    always_comb begin
        cond_flag = flags[2];
        case (cond_sel[1:0])
            COND_N:  cond_flag = flags[3];
            COND_Z:  cond_flag = flags[2];
            COND_C:  cond_flag = flags[1];
            COND_V:  cond_flag = flags[0];
            default: cond_flag = flags[2];
        endcase
    end

    // Next-address selection and stack control; a stall suppresses stack motion
    always_comb begin
        adr_next = adr_inc;
        push     = 1'b0;
        pop      = 1'b0;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;
        case (seq_op)
            SEQ_JUMP:  adr_next = next_adr;
            SEQ_DISP1: adr_next = ADR_W'(DISP1_TABLE[{Op, Funct[5]}]);
            SEQ_DISP2: adr_next = ADR_W'(DISP2_TABLE[{Op, Funct[0]}]);
            SEQ_COND: begin
                if (cond_flag ^ cond_sel[COND_INV_BIT]) begin
                    adr_next = next_adr;
                end
            end
            SEQ_CALL: begin
                adr_next = next_adr;
                push     = !stack_full_c;
                set_ovf  = stack_full_c;
            end
            SEQ_RET: begin
                adr_next = stack_empty_c ? '0 : stack_top_c;
                pop      = !stack_empty_c;
                set_unf  = stack_empty_c;
            end
            default:   adr_next = adr_inc;
        endcase
        if (stall) begin
            push = 1'b0;
            pop  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adr       <= '0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else if (!stall) begin
            adr       <= adr_next;
            stack_ovf <= stack_ovf | set_ovf;
            stack_unf <= stack_unf | set_unf;
        end
    end

    micro_ret_stack #(
        .ADR_W       (ADR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (adr_inc),
        .top_c     (stack_top_c),
        .full_c    (stack_full_c),
        .empty_c   (stack_empty_c)
    );

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer against a queue-based reference model.
module tb_micro_sequencer;

    localparam int unsigned ADR_W = 6;
    localparam int unsigned DEPTH = 4;

    logic             clk;
    logic             reset;
    logic             stall;
    logic [2:0]       seq_op;
    logic [ADR_W-1:0] next_adr;
    logic [2:0]       cond_sel;
    logic [3:0]       flags;
    logic [1:0]       Op;
    logic [5:0]       Funct;
    logic [ADR_W-1:0] adr;
    logic             stack_ovf;
    logic             stack_unf;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [ADR_W-1:0] m_adr;
    logic             m_ovf;
    logic             m_unf;
    logic [ADR_W-1:0] m_stack [$];

    micro_sequencer #(.ADR_W(ADR_W), .STACK_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .seq_op    (seq_op),
        .next_adr  (next_adr),
        .cond_sel  (cond_sel),
        .flags     (flags),
        .Op        (Op),
        .Funct     (Funct),
        .adr       (adr),
        .stack_ovf (stack_ovf),
        .stack_unf (stack_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_adr = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_stack.delete();
    endtask

    // Behaviour of one clock edge, written from the op descriptions
    task automatic model_step();
        logic f;
        if (stall) return;
        case (seq_op)
            3'd1: m_adr = next_adr;
            3'd2: begin
                case (Op)
                    2'b00:   m_adr = Funct[5] ? 6'd7 : 6'd6;
                    2'b01:   m_adr = 6'd2;
                    2'b10:   m_adr = 6'd9;
                    default: m_adr = 6'd0;
                endcase
            end
            3'd3: m_adr = Funct[0] ? 6'd3 : 6'd4;
            3'd4: begin
                case (cond_sel[1:0])
                    2'd0:    f = flags[3];
                    2'd1:    f = flags[2];
                    2'd2:    f = flags[1];
                    default: f = flags[0];
                endcase
                if (f != cond_sel[2]) m_adr = next_adr;
                else                  m_adr = m_adr + 6'd1;
            end
            3'd5: begin
                if (m_stack.size() == DEPTH) m_ovf = 1'b1;
                else                         m_stack.push_back(m_adr + 6'd1);
                m_adr = next_adr;
            end
            3'd6: begin
                if (m_stack.size() == 0) begin
                    m_adr = '0;
                    m_unf = 1'b1;
                end else begin
                    m_adr = m_stack.pop_back();
                end
            end
            default: m_adr = m_adr + 6'd1;
        endcase
    endtask

    // Drive one microword, advance one edge, leave time at posedge+1
    task automatic apply(input logic [2:0] op, input logic [ADR_W-1:0] na,
                         input logic [2:0] cs, input logic [3:0] fl,
                         input logic [1:0] o, input logic [5:0] fn, input logic st);
        seq_op = op; next_adr = na; cond_sel = cs; flags = fl;
        Op = o; Funct = fn; stall = st;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; seq_op = '0; next_adr = '0;
        cond_sel = '0; flags = '0; Op = '0; Funct = '0;
        model_reset();
        #3;
        n_checks++;
        if (adr !== 6'd0 || stack_ovf !== 1'b0 || stack_unf !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: adr=%0d ovf=%b unf=%b expected 0 0 0", adr, stack_ovf, stack_unf);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_next();
        for (int i = 1; i <= 3; i++) begin
            apply(3'd0, '0, '0, '0, '0, '0, 1'b0);
            n_checks++;
            if (adr !== 6'(i) || adr !== m_adr) begin
                n_errors++;
                $display("FAIL next_count: adr=%0d expected %0d", adr, i);
            end
        end
        apply(3'd1, 6'd63, '0, '0, '0, '0, 1'b0);
        apply(3'd0, '0, '0, '0, '0, '0, 1'b0);
        n_checks++;
        if (adr !== 6'd0) begin
            n_errors++;
            $display("FAIL next_wrap: adr=%0d expected 0", adr);
        end
        apply(3'd7, '0, '0, '0, '0, '0, 1'b0);
        n_checks++;
        if (adr !== 6'd1) begin
            n_errors++;
            $display("FAIL undefined_op: adr=%0d expected 1", adr);
        end
    endtask

    task automatic test_dispatch();
        apply(3'd2, '0, '0, '0, 2'b00, 6'b100000, 1'b0);
        n_checks++;
        if (adr !== 6'd7) begin
            n_errors++;
            $display("FAIL disp1_op00_f5: adr=%0d expected 7", adr);
        end
        apply(3'd2, '0, '0, '0, 2'b10, 6'b000000, 1'b0);
        n_checks++;
        if (adr !== 6'd9) begin
            n_errors++;
            $display("FAIL disp1_op10: adr=%0d expected 9", adr);
        end
        apply(3'd3, '0, '0, '0, 2'b01, 6'b000001, 1'b0);
        n_checks++;
        if (adr !== 6'd3) begin
            n_errors++;
            $display("FAIL disp2_f0: adr=%0d expected 3", adr);
        end
        apply(3'd3, '0, '0, '0, 2'b11, 6'b111110, 1'b0);
        n_checks++;
        if (adr !== 6'd4) begin
            n_errors++;
            $display("FAIL disp2_nf0: adr=%0d expected 4", adr);
        end
    endtask

    task automatic test_cond();
        apply(3'd1, 6'd10, '0, '0, '0, '0, 1'b0);
        apply(3'd4, 6'd20, 3'b001, 4'b0100, '0, '0, 1'b0);
        n_checks++;
        if (adr !== 6'd20) begin
            n_errors++;
            $display("FAIL cond_z_taken: adr=%0d expected 20", adr);
        end
        apply(3'd4, 6'd40, 3'b101, 4'b0100, '0, '0, 1'b0);
        n_checks++;
        if (adr !== 6'd21) begin
            n_errors++;
            $display("FAIL cond_z_inverted: adr=%0d expected 21", adr);
        end
    endtask

    task automatic test_call_ret();
        logic [ADR_W-1:0] exp_ret [4];
        exp_ret[0] = 6'd43; exp_ret[1] = 6'd42; exp_ret[2] = 6'd41; exp_ret[3] = 6'd31;
        apply(3'd1, 6'd5, '0, '0, '0, '0, 1'b0);
        apply(3'd5, 6'd12, '0, '0, '0, '0, 1'b0);
        n_checks++;
        if (adr !== 6'd12) begin
            n_errors++;
            $display("FAIL call_target: adr=%0d expected 12", adr);
        end
        apply(3'd6, '0, '0, '0, '0, '0, 1'b0);
        n_checks++;
        if (adr !== 6'd6) begin
            n_errors++;
            $display("FAIL ret_simple: adr=%0d expected 6", adr);
        end
        apply(3'd1, 6'd30, '0, '0, '0, '0, 1'b0);
        for (int i = 0; i < 5; i++) apply(3'd5, 6'(40 + i), '0, '0, '0, '0, 1'b0);
        n_checks++;
        if (adr !== 6'd44 || stack_ovf !== 1'b1 || stack_unf !== 1'b0) begin
            n_errors++;
            $display("FAIL call_overflow: adr=%0d ovf=%b unf=%b expected 44 1 0", adr, stack_ovf, stack_unf);
        end
        for (int i = 0; i < 4; i++) begin
            apply(3'd6, '0, '0, '0, '0, '0, 1'b0);
            n_checks++;
            if (adr !== exp_ret[i] || adr !== m_adr) begin
                n_errors++;
                $display("FAIL ret_lifo: adr=%0d expected %0d", adr, exp_ret[i]);
            end
        end
    endtask

    task automatic test_underflow_stall();
        apply(3'd1, 6'd17, '0, '0, '0, '0, 1'b0);
        apply(3'd6, '0, '0, '0, '0, '0, 1'b0);
        n_checks++;
        if (adr !== 6'd0 || stack_unf !== 1'b1) begin
            n_errors++;
            $display("FAIL ret_underflow: adr=%0d unf=%b expected 0 1", adr, stack_unf);
        end
        apply(3'd0, '0, '0, '0, '0, '0, 1'b0);
        n_checks++;
        if (stack_unf !== 1'b1 || stack_ovf !== 1'b1) begin
            n_errors++;
            $display("FAIL flags_sticky: ovf=%b unf=%b expected 1 1", stack_ovf, stack_unf);
        end
        apply(3'd1, 6'd8, '0, '0, '0, '0, 1'b0);
        apply(3'd5, 6'd50, '0, '0, '0, '0, 1'b0);
        apply(3'd5, 6'd60, '0, '0, '0, '0, 1'b1);
        n_checks++;
        if (adr !== 6'd50) begin
            n_errors++;
            $display("FAIL stall_call_adr: adr=%0d expected 50", adr);
        end
        apply(3'd6, '0, '0, '0, '0, '0, 1'b0);
        n_checks++;
        if (adr !== 6'd9) begin
            n_errors++;
            $display("FAIL stall_call_ptr: adr=%0d expected 9", adr);
        end
        apply(3'd6, '0, '0, '0, '0, '0, 1'b0);
        n_checks++;
        if (adr !== 6'd0) begin
            n_errors++;
            $display("FAIL stall_then_empty: adr=%0d expected 0", adr);
        end
    endtask

    task automatic test_reset_mid();
        apply(3'd1, 6'd3, '0, '0, '0, '0, 1'b0);
        apply(3'd5, 6'd25, '0, '0, '0, '0, 1'b0);
        apply(3'd5, 6'd35, '0, '0, '0, '0, 1'b0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (adr !== 6'd0 || stack_ovf !== 1'b0 || stack_unf !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_async: adr=%0d ovf=%b unf=%b expected 0 0 0", adr, stack_ovf, stack_unf);
        end
        @(negedge clk);
        reset = 1'b0;
        apply(3'd6, '0, '0, '0, '0, '0, 1'b0);
        n_checks++;
        if (adr !== 6'd0 || stack_unf !== 1'b1 || stack_ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_discards_stack: adr=%0d unf=%b ovf=%b expected 0 1 0", adr, stack_unf, stack_ovf);
        end
    endtask

    task automatic test_random();
        reset = 1'b1;
        model_reset();
        #1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 400; i++) begin
            apply(3'($urandom_range(0, 7)), 6'($urandom), 3'($urandom), 4'($urandom),
                  2'($urandom), 6'($urandom), ($urandom_range(0, 7) == 0));
            n_checks++;
            if (adr !== m_adr || stack_ovf !== m_ovf || stack_unf !== m_unf) begin
                n_errors++;
                $display("FAIL random_%0d: adr=%0d ovf=%b unf=%b expected %0d %b %b",
                         i, adr, stack_ovf, stack_unf, m_adr, m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_next();
        test_dispatch();
        test_cond();
        test_call_ret();
        test_underflow_stall();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
